core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
- Memory-side responder for the single-cycle RISC-V core: serves the instruction fetch port and the data load/store port.
- Contains instruction memory, data memory and a byte-stream boot loader that fills instruction memory after reset.
- While loading, it holds the core in reset. When loading completes, it releases the core and serves fetches and loads/stores with zero read latency.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (power of 2).
- DMEM_WORDS, 256, data memory depth in 32-bit words (power of 2).
- NOP_INSTR, 32'h00000013, word returned for invalid fetches (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_addr_to_mem  in  32  fetch byte address from core.
- instr_op_from_mem  out  32  fetched instruction word.
- alu_out  in  32  data byte address.
- data_read_2  in  32  store data.
- CU_mem_write  in  1  store request.
- CU_mem_read  in  1  load request.
- mem_read_data  out  32  load data.
- ld_valid  in  1  loader byte valid.
- ld_byte  in  8  loader byte.
- ld_last  in  1  final byte of image; qualified by ld_valid.
- ld_ready  out  1  loader accepts a byte this cycle.
- core_reset  out  1  reset to core; high while loading.
- load_words  out  16  instruction words written by the last load.
- dmem_err  out  1  sticky bad data access flag.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - state=LOAD, core_reset=1, ld_ready=1.
  - byte counter=0, word pointer=0, load_words=0, dmem_err=0.
  - Memory arrays are not cleared.
- FSM states: LOAD, RUN.
- LOAD state:
  - A byte is accepted on any edge where ld_valid=1, since ld_ready=1 throughout.
  - Bytes are little-endian: byte k goes to bits [8k+7:8k], with k = byte counter 0..3.
  - On the 4th byte, the assembled word is written to imem[word pointer]. The pointer increments, load_words increments, and the counter returns to 0.
- Transition LOAD -> RUN, either condition:
  - An accepted byte has ld_last=1. A partial word is written with its unfilled upper bytes set to 0 and counts in load_words.
  - A word is written at pointer IMEM_WORDS-1; the image is full.
  - Later bytes are not accepted.
- RUN state:
  - core_reset=0 and ld_ready=0.
  - The FSM stays in RUN until reset.
- core_reset is registered:
  - It falls on the same edge that enters RUN, so the core's first cycle out of reset fetches address 0.
  - It is re-asserted on the same edge that reset is sampled.
- Fetch (combinational, 0 latency):
  - Word index = instr_addr_to_mem[31:2].
  - Returns imem[index] if index < IMEM_WORDS, state=RUN and addr[1:0]=0. Otherwise returns NOP_INSTR.
- Load (combinational, 0 latency):
  - Word index = alu_out[31:2].
  - If CU_mem_read=1, the index is in range and alu_out[1:0]=0, returns dmem[index]. Otherwise returns 0.
- Store (synchronous):
  - On the edge where CU_mem_write=1, state=RUN, the index is in range and alu_out[1:0]=0, data_read_2 is written to dmem[index].
- Read and write to the same address in the same cycle: the read returns the old data. The new data is visible from the next cycle.
- dmem_err is set on any edge in RUN where (CU_mem_read or CU_mem_write) is 1 and the address is out of range or misaligned.
  - The offending store is dropped.
  - The flag stays set until reset.
- Requests in LOAD: CU_mem_write/CU_mem_read are ignored; no write and no error. The core is in reset.
- Reset mid-load:
  - The pointer and counter return to 0 and load_words=0.
  - Already-written imem words persist until overwritten.
- Width rules:
  - load_words saturates at 16'hFFFF; it cannot exceed IMEM_WORDS for legal depths.
  - Addresses above the array depth are never aliased.

Test Plan:
- Reset, then stream bytes 13 05 A0 00 / 93 05 B0 00 with ld_last on the 8th byte:
  - imem[0]=32'h00A00513 and imem[1]=32'h00B00593.
  - load_words=2, core_reset falls on the edge accepting the 8th byte.
  - Fetch addr 0x4 returns 32'h00B00593.
- Stream 6 bytes 11 22 33 44 55 66 with ld_last on the 6th:
  - imem[1]=32'h00006655 and load_words=2.
  - Fetch addr 0x8 returns the previous imem[2] contents; fetch 0x401 returns 32'h00000013.
- In RUN:
  - Store 32'hDEADBEEF to 0x10 with CU_mem_read=1 at 0x10 in the same cycle: mem_read_data is the old value that cycle and 32'hDEADBEEF the next.
  - CU_mem_read=0 gives mem_read_data=0.
- Store to 0x12 (misaligned), then to 0x400 (out of range with DMEM_WORDS=256):
  - No dmem change; dmem_err=1 from the first offending edge and stays 1.
  - Reset clears it.
- With IMEM_WORDS=4, stream 20 bytes without ld_last:
  - After byte 16, state=RUN and ld_ready=0; bytes 17-20 are not accepted.
  - load_words=4.
- Assert reset after 5 bytes of a load, then stream 4 bytes AA BB CC DD with ld_last:
  - imem[0]=32'hDDCCBBAA and load_words=1.
  - core_reset stays high until that last byte.

Source files
------------

// File: rtl/core_mem_responder.sv
// core_mem_responder
// Memory-side responder for the single-cycle core: instruction memory filled
// by a little-endian byte-stream boot loader, data memory for loads/stores,
// and a registered core reset that is held until the image is in place.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   LOAD  | boot loader accepts bytes, core held in reset, no data access
//   RUN   | image loaded, core released, fetch/load/store served
module core_mem_responder #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr_to_mem,
  output logic [31:0] instr_op_from_mem,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_read_2,
  input  logic        CU_mem_write,
  input  logic        CU_mem_read,
  output logic [31:0] mem_read_data,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_reset,
  output logic [15:0] load_words,
  output logic        dmem_err
);

  localparam int IA_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DA_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [IA_W-1:0] IPTR_LAST = IA_W'(IMEM_WORDS - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic [1:0]      byte_cnt;
  logic [23:0]     byte_buf;
  logic [IA_W-1:0] word_ptr;

  logic        ld_accept;
  logic        ld_word_wr;
  logic        ld_full;
  logic [31:0] ld_word;

  logic [29:0] if_idx;
  logic        if_hit;
  logic [29:0] dm_idx;
  logic        dm_ok;
  logic        dm_req;
  logic        dm_we;

  // Loader datapath: merge the incoming byte into the partial word; unfilled
  // upper bytes stay zero so a short final word is written zero-padded.
  always_comb begin
    ld_accept  = (state == LOAD) && ld_valid;
    ld_word_wr = ld_accept && (ld_last || (byte_cnt == 2'd3));
    ld_full    = ld_word_wr && (word_ptr == IPTR_LAST);
    ld_word    = 32'h0;
    case (byte_cnt)
      2'd0:    ld_word = {24'h0, ld_byte};
      2'd1:    ld_word = {16'h0, ld_byte, byte_buf[7:0]};
      2'd2:    ld_word = {8'h0, ld_byte, byte_buf[15:0]};
      default: ld_word = {ld_byte, byte_buf};
    endcase
  end

  // FSM next state and loader handshake; RUN is terminal until reset.
  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_accept && (ld_last || ld_full)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // State register; core_reset follows the next state so it drops on the
  // very edge that enters RUN and rises on the edge that samples reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      core_reset <= 1'b1;
    end else begin
      state      <= state_next;
      core_reset <= (state_next != RUN);
    end
  end

  // Loader byte counter, partial-word buffer, word pointer and word count.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      byte_buf   <= 24'h0;
      word_ptr   <= '0;
      load_words <= 16'h0;
    end else if (ld_accept) begin
      if (ld_word_wr) begin
        byte_cnt <= 2'd0;
        word_ptr <= word_ptr + 1'b1;
        if (load_words != 16'hFFFF) begin
          load_words <= load_words + 16'd1;
        end
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
        byte_buf <= ld_word[23:0];
      end
    end
  end

  // Instruction memory write port, driven only by the loader.
  always_ff @(posedge clk) begin
    if (!reset && ld_word_wr) begin
      imem[word_ptr] <= ld_word;
    end
  end

  // Fetch: zero latency; anything not aligned, in range and in RUN is a NOP.
  always_comb begin
    if_idx            = instr_addr_to_mem[31:2];
    if_hit            = (state == RUN) && (instr_addr_to_mem[1:0] == 2'b00) &&
                        ({2'b00, if_idx} < 32'(IMEM_WORDS));
    instr_op_from_mem = NOP_INSTR;
    if (if_hit) begin
      instr_op_from_mem = imem[if_idx[IA_W-1:0]];
    end
  end

  // Data access decode: full-address range check so nothing aliases.
  always_comb begin
    dm_idx        = alu_out[31:2];
    dm_ok         = (alu_out[1:0] == 2'b00) && ({2'b00, dm_idx} < 32'(DMEM_WORDS));
    dm_req        = (state == RUN) && (CU_mem_read || CU_mem_write);
    dm_we         = (state == RUN) && CU_mem_write && dm_ok;
    mem_read_data = 32'h0;
    if (CU_mem_read && dm_ok) begin
      mem_read_data = dmem[dm_idx[DA_W-1:0]];
    end
  end

  // Data memory write port; bad stores are dropped by dm_we.
  always_ff @(posedge clk) begin
    if (!reset && dm_we) begin
      dmem[dm_idx[DA_W-1:0]] <= data_read_2;
    end
  end

  // Sticky flag for misaligned or out-of-range data accesses in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_err <= 1'b0;
    end else if (dm_req && !dm_ok) begin
      dmem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: image loads against a byte-list model of
// instruction memory, randomized data traffic against an array model, a
// table of directed data-port vectors, and a 4-word instance for image-full.
module tb_core_mem_responder;

  localparam int          IW  = 256;
  localparam int          DW  = 256;
  localparam int          SW  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef logic [7:0] bytes_q_t[$];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } dvec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] instr_addr, instr_op, alu_out, data_in, rd_data;
  logic        cu_write, cu_read;
  logic        ld_valid, ld_last, ld_ready, core_reset, dmem_err;
  logic [7:0]  ld_byte;
  logic [15:0] load_words;

  logic [31:0] instr_addr_s, instr_op_s, rd_data_s;
  logic        ld_valid_s, ld_last_s, ld_ready_s, core_reset_s, dmem_err_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] load_words_s;
  logic [31:0] zero32;
  logic        zero1;

  core_mem_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .instr_addr_to_mem(instr_addr), .instr_op_from_mem(instr_op),
    .alu_out(alu_out), .data_read_2(data_in),
    .CU_mem_write(cu_write), .CU_mem_read(cu_read), .mem_read_data(rd_data),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .core_reset(core_reset), .load_words(load_words), .dmem_err(dmem_err)
  );

  core_mem_responder #(.IMEM_WORDS(SW), .DMEM_WORDS(16), .NOP_INSTR(NOP)) dut_s (
    .clk(clk), .reset(reset),
    .instr_addr_to_mem(instr_addr_s), .instr_op_from_mem(instr_op_s),
    .alu_out(zero32), .data_read_2(zero32),
    .CU_mem_write(zero1), .CU_mem_read(zero1), .mem_read_data(rd_data_s),
    .ld_valid(ld_valid_s), .ld_byte(ld_byte_s), .ld_last(ld_last_s), .ld_ready(ld_ready_s),
    .core_reset(core_reset_s), .load_words(load_words_s), .dmem_err(dmem_err_s)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] imem_m [IW];
  bit          imem_k [IW];
  logic [31:0] dmem_m [DW];
  bit          dmem_k [DW];
  bit          err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // Image model: whole words from the byte list, last partial word zero-padded
  // when the image is terminated, capped at the memory depth.
  function automatic int model_load(input bytes_q_t img, input bit has_last);
    int n;
    int nw;
    n  = img.size();
    nw = has_last ? (n + 3) / 4 : n / 4;
    if (nw > IW) nw = IW;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) word[8*k +: 8] = img[4*w+k];
      end
      imem_m[w] = word;
      imem_k[w] = 1'b1;
    end
    return nw;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic drive_load(input bytes_q_t img, input bit has_last, input bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          ld_valid = 1'b0;
          ld_last  = 1'b0;
        end
      end
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = img[i];
      ld_last  = has_last && (i == img.size() - 1);
      #1;
      check("ld_ready_loading", 32'(ld_ready), 32'd1);
      check("core_reset_pre_edge", 32'(core_reset), 32'd1);
      @(posedge clk);
      #1;
      if (ld_last) check("core_reset_release", 32'(core_reset), 32'd0);
      else         check("core_reset_held", 32'(core_reset), 32'd1);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    instr_addr = addr;
    #1;
    check(name, instr_op, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_q_t    img;
    dvec_t       tbl[$];
    int          nw;
    logic [31:0] a, ia, idx, fi;
    bit          good;

    reset = 1'b1; instr_addr = 0; alu_out = 0; data_in = 0; cu_write = 0; cu_read = 0;
    ld_valid = 0; ld_byte = 0; ld_last = 0;
    instr_addr_s = 0; ld_valid_s = 0; ld_byte_s = 0; ld_last_s = 0;
    zero32 = 0; zero1 = 0; err_m = 0;
    for (int i = 0; i < IW; i++) imem_k[i] = 1'b0;
    for (int i = 0; i < DW; i++) dmem_k[i] = 1'b0;

    // reset values
    do_reset();
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_load_words", 32'(load_words), 32'd0);
    check("rst_dmem_err", 32'(dmem_err), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    fetch_check("rst_fetch_nop", 32'h0, NOP);
    check("rst_s_core_reset", 32'(core_reset_s), 32'd1);
    check("rst_s_ld_ready", 32'(ld_ready_s), 32'd1);
    check("rst_s_load_words", 32'(load_words_s), 32'd0);

    // random image with gaps; data requests during LOAD must be ignored
    img = {};
    for (int i = 0; i < 37; i++) img.push_back(8'($urandom_range(0, 255)));
    cu_write = 1'b1; cu_read = 1'b1; alu_out = 32'h3; data_in = 32'h0BADF00D;
    drive_load(img, 1'b1, 1'b1);
    cu_write = 1'b0; cu_read = 1'b0;
    nw = model_load(img, 1'b1);
    check("img1_load_words", 32'(load_words), 32'(nw));
    check("img1_ld_ready", 32'(ld_ready), 32'd0);
    check("img1_err_in_load", 32'(dmem_err), 32'd0);
    for (int w = 0; w < nw; w++) fetch_check($sformatf("img1_fetch%0d", w), 32'(w * 4), imem_m[w]);

    // randomized data/fetch traffic in RUN
    for (int t = 0; t < 300; t++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = 32'($urandom_range(0, 15)) << 2;
      else if (sel == 6) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 7) a = 32'($urandom_range(256, 1023)) << 2;
      else if (sel == 8) a = $urandom();
      else               a = 32'($urandom_range(0, 255)) << 2;
      sel = $urandom_range(0, 3);
      if (sel <= 1)      ia = 32'($urandom_range(0, 11)) << 2;
      else if (sel == 2) ia = (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(1, 3));
      else               ia = $urandom();
      @(negedge clk);
      alu_out = a; instr_addr = ia; data_in = $urandom();
      cu_write = 1'($urandom_range(0, 1)); cu_read = 1'($urandom_range(0, 1));
      #1;
      idx  = a >> 2;
      good = (a[1:0] == 2'b00) && (idx < DW);
      if (cu_read && good) begin
        if (dmem_k[idx[7:0]]) check("rand_rd", rd_data, dmem_m[idx[7:0]]);
      end else begin
        check("rand_rd_zero", rd_data, 32'h0);
      end
      check("rand_err", 32'(dmem_err), 32'(err_m));
      fi = ia >> 2;
      if (ia[1:0] == 2'b00 && fi < IW) begin
        if (imem_k[fi[7:0]]) check("rand_fetch", instr_op, imem_m[fi[7:0]]);
      end else begin
        check("rand_fetch_nop", instr_op, NOP);
      end
      @(posedge clk);
      if (cu_write && good) begin
        dmem_m[idx[7:0]] = data_in;
        dmem_k[idx[7:0]] = 1'b1;
      end
      if ((cu_read || cu_write) && !good) err_m = 1'b1;
    end
    @(negedge clk);
    cu_write = 1'b0; cu_read = 1'b0;

    // two-word image from the reference program
    do_reset();
    check("tp1_err_cleared", 32'(dmem_err), 32'd0);
    check("tp1_load_words_rst", 32'(load_words), 32'd0);
    fetch_check("tp1_fetch_in_load", 32'h0, NOP);
    img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    drive_load(img, 1'b1, 1'b0);
    nw = model_load(img, 1'b1);
    check("tp1_load_words", 32'(load_words), 32'd2);
    fetch_check("tp1_fetch0", 32'h0, 32'h00A00513);
    fetch_check("tp1_fetch4", 32'h4, 32'h00B00593);

    // partial final word, older contents beyond the image survive
    do_reset();
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    drive_load(img, 1'b1, 1'b0);
    nw = model_load(img, 1'b1);
    check("tp2_load_words", 32'(load_words), 32'd2);
    fetch_check("tp2_fetch0", 32'h0, 32'h44332211);
    fetch_check("tp2_fetch4", 32'h4, 32'h00006655);
    fetch_check("tp2_fetch8_old", 32'h8, imem_m[2]);
    fetch_check("tp2_fetch401", 32'h401, NOP);
    fetch_check("tp2_fetch400", 32'h400, NOP);
    fetch_check("tp2_fetch2", 32'h2, NOP);

    // directed data-port vectors
    tbl.push_back('{1'b1, 1'b0, 32'h000, 32'hA5A5A5A5, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h010, 32'h11111111, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h010, 32'hDEADBEEF, 32'h11111111, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h010, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h020, 32'hCAFEF00D, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h020, 32'h0, 32'hCAFEF00D, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h012, 32'h12345678, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h010, 32'h0, 32'hDEADBEEF, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 32'h400, 32'h55555555, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h000, 32'h0, 32'hA5A5A5A5, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h400, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h011, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 32'h3FC, 32'h77777777, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h3FC, 32'h0, 32'h77777777, 1'b1});
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      cu_write = tbl[i].wr; cu_read = tbl[i].rd;
      alu_out = tbl[i].addr; data_in = tbl[i].wdata;
      #1;
      check($sformatf("tbl%0d_rd", i), rd_data, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), 32'(dmem_err), 32'(tbl[i].exp_err));
      @(posedge clk);
    end
    @(negedge clk);
    cu_write = 1'b0; cu_read = 1'b0;

    // reset in the middle of a load, with stores attempted while loading
    do_reset();
    check("mid_err_cleared", 32'(dmem_err), 32'd0);
    cu_write = 1'b1; alu_out = 32'h20; data_in = 32'h0;
    img = {};
    for (int i = 0; i < 5; i++) img.push_back(8'($urandom_range(0, 255)));
    drive_load(img, 1'b0, 1'b0);
    nw = model_load(img, 1'b0);
    do_reset();
    check("mid_core_reset", 32'(core_reset), 32'd1);
    check("mid_load_words_rst", 32'(load_words), 32'd0);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    drive_load(img, 1'b1, 1'b0);
    cu_write = 1'b0;
    nw = model_load(img, 1'b1);
    check("mid_load_words", 32'(load_words), 32'd1);
    fetch_check("mid_fetch0", 32'h0, 32'hDDCCBBAA);
    fetch_check("mid_fetch4_old", 32'h4, imem_m[1]);
    check("mid_err", 32'(dmem_err), 32'd0);
    cu_read = 1'b1; alu_out = 32'h20;
    #1;
    check("mid_store_dropped", rd_data, 32'hCAFEF00D);
    @(negedge clk);
    cu_read = 1'b0;

    // 4-word instance: image fills memory after 16 bytes, rest refused
    img = {};
    for (int i = 0; i < 16; i++) img.push_back(8'(8'h10 + i));
    for (int i = 0; i < 4; i++)  img.push_back(8'(8'hF0 + i));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ld_valid_s = 1'b1; ld_byte_s = img[i]; ld_last_s = 1'b0;
      @(posedge clk);
      #1;
      if (i == 14) begin
        check("s_ready_b15", 32'(ld_ready_s), 32'd1);
        check("s_core_reset_b15", 32'(core_reset_s), 32'd1);
        check("s_words_b15", 32'(load_words_s), 32'd3);
      end
      if (i == 15) begin
        check("s_ready_b16", 32'(ld_ready_s), 32'd0);
        check("s_core_reset_b16", 32'(core_reset_s), 32'd0);
        check("s_words_b16", 32'(load_words_s), 32'd4);
      end
    end
    @(negedge clk);
    ld_valid_s = 1'b0;
    check("s_words_final", 32'(load_words_s), 32'd4);
    for (int w = 0; w < SW; w++) begin
      instr_addr_s = 32'(w * 4);
      #1;
      check($sformatf("s_fetch%0d", w), instr_op_s,
            {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
    end
    instr_addr_s = 32'h10;
    #1;
    check("s_fetch_oob", instr_op_s, NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
